sprite_mover: RTL and testbench

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_mover_pkg.sv | 39 +++
 rtl/sprite_mover_btn_sync.sv | 31 +++
 rtl/sprite_mover.sv | 165 ++++++++++++++++
 tb/tb_sprite_mover.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_mover_pkg.sv
// Shared definitions for the sprite mover.
//   state_t    : two-state run/idle FSM encoding
//   C_*        : RGB565 colour constants used as parameter defaults
//   BTN_*      : bit positions of the buttons in the synchroniser bus
//   step_axis  : one-pixel move along an axis with clamp or wrap at the bounds
package sprite_mover_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] C_WHITE = 16'hFFFF;
    localparam logic [15:0] C_BLUE  = 16'h001F;
    localparam logic [15:0] C_BLACK = 16'h0000;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_START = 4;

    // Move pos by one pixel toward hi (inc=1) or lo (inc=0). At a bound the
    // step is dropped in clamp mode, or the opposite bound is loaded in wrap mode.
    function automatic int step_axis(input int pos, input logic inc,
                                     input int lo, input int hi, input logic wrap);
        int r;
        r = pos;
        if (inc) begin
            if (pos >= hi) r = wrap ? lo : pos;
            else           r = pos + 1;
        end else begin
            if (pos <= lo) r = wrap ? hi : pos;
            else           r = pos - 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_mover_btn_sync.sv
// Two-flop synchroniser plus rising-edge detector for one pushbutton.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_btn          : raw button, asynchronous to i_clk
//   o_level        : synchronised level
//   o_rise         : one-cycle pulse on a synchronised 0->1 transition
module btn_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    logic r_s1, r_s2, r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/sprite_mover.sv
// Moves a square sprite around a small OLED frame under pushbutton control.
//   CLOCK, RST_N          : clock, asynchronous active-low reset
//   btn_*                 : raw pushbuttons (synchronised internally)
//   speed_sel             : 1 = DIV_SLOW cycles per step, 0 = DIV_FAST
//   wrap_en               : 1 = wrap at the edges, 0 = clamp
//   pixel_index           : linear pixel address from the display driver
//   pixel_data            : RGB565 colour for pixel_index, one cycle later
//   pos_x, pos_y, running : sprite top-left corner and run flag
module sprite_mover
    import sprite_mover_pkg::*;
#(
    parameter int          SCR_W    = 96,
    parameter int          SCR_H    = 64,
    parameter int          SPR      = 6,
    parameter int          START_X  = 45,
    parameter int          START_Y  = 55,
    parameter int          MARGIN   = 2,
    parameter int          DIV_SLOW = 3_333_000,
    parameter int          DIV_FAST = 2_222_000,
    parameter logic [15:0] FG       = C_WHITE,
    parameter logic [15:0] IDLE_C   = C_BLUE,
    parameter logic [15:0] BG       = C_BLACK
) (
    input  logic        CLOCK,
    input  logic        RST_N,
    input  logic        btn_start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        speed_sel,
    input  logic        wrap_en,
    input  logic [12:0] pixel_index,
    output logic [15:0] pixel_data,
    output logic [6:0]  pos_x,
    output logic [5:0]  pos_y,
    output logic        running
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int X_LO    = MARGIN;
    localparam int X_HI    = SCR_W - SPR - MARGIN;
    localparam int Y_LO    = MARGIN;
    localparam int Y_HI    = SCR_H - SPR - MARGIN;

    // ---------------- button synchronisers ----------------
    logic [4:0] w_raw, w_lvl, w_rise;
    logic [4:0] w_unused_rise;

    assign w_raw = {btn_start, btn_up, btn_down, btn_left, btn_right};

    for (genvar g = 0; g < 5; g++) begin : g_sync
        btn_sync u_sync (
            .i_clk   (CLOCK),
            .i_rst_n (RST_N),
            .i_btn   (w_raw[g]),
            .o_level (w_lvl[g]),
            .o_rise  (w_rise[g])
        );
    end

    // Only start is edge-triggered; direction buttons act on level.
    assign w_unused_rise = {w_lvl[BTN_START], w_rise[3:0]};

    logic w_start;
    assign w_start = w_rise[BTN_START];

    // ---------------- FSM ----------------
    state_t r_state, w_state_nxt;

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) w_state_nxt = RUN;
    end

    always_comb begin
        running = (r_state == RUN);
    end

    // ---------------- step counters ----------------
    int         w_div;
    logic       w_x_act, w_y_act, w_x_step, w_y_step;
    logic [CW-1:0] r_cnt_x, r_cnt_y;

    assign w_div = speed_sel ? DIV_SLOW : DIV_FAST;

    // An axis is active only with exactly one of its two buttons held.
    assign w_x_act  = running && (w_lvl[BTN_LEFT] ^ w_lvl[BTN_RIGHT]);
    assign w_y_act  = running && (w_lvl[BTN_UP]   ^ w_lvl[BTN_DOWN]);
    assign w_x_step = w_x_act && (r_cnt_x == '0);
    assign w_y_step = w_y_act && (r_cnt_y == '0);

    // ">=" rather than "==" so a counter left beyond a newly selected,
    // smaller divider still wraps on the next cycle.
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt_x <= '0;
            r_cnt_y <= '0;
        end else begin
            if (w_start || !w_x_act)             r_cnt_x <= '0;
            else if (int'(r_cnt_x) >= w_div - 1) r_cnt_x <= '0;
            else                                 r_cnt_x <= r_cnt_x + CW'(1);

            if (w_start || !w_y_act)             r_cnt_y <= '0;
            else if (int'(r_cnt_y) >= w_div - 1) r_cnt_y <= '0;
            else                                 r_cnt_y <= r_cnt_y + CW'(1);
        end
    end

    // ---------------- position ----------------
    logic [6:0] r_pos_x;
    logic [5:0] r_pos_y;

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            r_pos_x <= 7'(START_X);
            r_pos_y <= 6'(START_Y);
        end else if (w_start) begin
            r_pos_x <= 7'(START_X);
            r_pos_y <= 6'(START_Y);
        end else begin
            if (w_x_step)
                r_pos_x <= 7'(step_axis(int'(r_pos_x), w_lvl[BTN_RIGHT], X_LO, X_HI, wrap_en));
            if (w_y_step)
                r_pos_y <= 6'(step_axis(int'(r_pos_y), w_lvl[BTN_DOWN], Y_LO, Y_HI, wrap_en));
        end
    end

    assign pos_x = r_pos_x;
    assign pos_y = r_pos_y;

    // ---------------- pixel generation ----------------
    int          w_px, w_py;
    logic [15:0] w_pix_nxt, r_pix;

    always_comb begin
        w_px      = int'(pixel_index) % SCR_W;
        w_py      = int'(pixel_index) / SCR_W;
        w_pix_nxt = BG;
        if (running) begin
            if (w_px >= int'(r_pos_x) && w_px < int'(r_pos_x) + SPR &&
                w_py >= int'(r_pos_y) && w_py < int'(r_pos_y) + SPR)
                w_pix_nxt = FG;
        end else begin
            // Fixed marker in the top-left corner while waiting for start.
            if (w_px >= MARGIN && w_px <= MARGIN + SPR - 1 &&
                w_py >= MARGIN && w_py <= MARGIN + SPR - 1)
                w_pix_nxt = IDLE_C;
        end
    end

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) r_pix <= BG;
        else        r_pix <= w_pix_nxt;
    end

    assign pixel_data = r_pix;

endmodule

// File: tb/tb_sprite_mover.sv
module tb_sprite_mover;

    logic        CLOCK = 1'b0;
    logic        RST_N;
    logic        btn_start, btn_up, btn_down, btn_left, btn_right;
    logic        speed_sel, wrap_en;
    logic [12:0] pixel_index;
    logic [15:0] pixel_data;
    logic [6:0]  pos_x;
    logic [5:0]  pos_y;
    logic        running;

    always #5 CLOCK = ~CLOCK;

    sprite_mover #(
        .SCR_W(96), .SCR_H(64), .SPR(6), .START_X(45), .START_Y(55), .MARGIN(2),
        .DIV_SLOW(8), .DIV_FAST(4),
        .FG(16'hFFFF), .IDLE_C(16'h001F), .BG(16'h0000)
    ) dut (
        .CLOCK(CLOCK), .RST_N(RST_N),
        .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .speed_sel(speed_sel), .wrap_en(wrap_en),
        .pixel_index(pixel_index), .pixel_data(pixel_data),
        .pos_x(pos_x), .pos_y(pos_y), .running(running)
    );

    // kinds: 0 pos_x, 1 pos_y, 2 running, 3 pixel_data, 4 X counter
    typedef struct {
        string name;
        int    kind;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_v(input string n, input int k, input int v);
        exp_t e;
        e.name = n; e.kind = k; e.val = v;
        sbq.push_back(e);
    endtask

    function automatic int actual(input int k);
        case (k)
            0:       return int'(pos_x);
            1:       return int'(pos_y);
            2:       return int'(running);
            3:       return int'(pixel_data);
            default: return int'(dut.r_cnt_x);
        endcase
    endfunction

    // Monitor: drains the scoreboard on every falling edge.
    initial begin
        forever begin
            @(negedge CLOCK);
            while (sbq.size() > 0) begin
                exp_t e;
                int   a;
                e = sbq.pop_front();
                a = actual(e.kind);
                total++;
                if (a != e.val) begin
                    bad++;
                    $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, a, e.val, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic press(input logic [3:0] m, input int n); // {up,down,left,right}
        @(negedge CLOCK);
        {btn_up, btn_down, btn_left, btn_right} = m;
        repeat (n) @(posedge CLOCK);
        @(negedge CLOCK);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic start_pulse();
        @(negedge CLOCK);
        btn_start = 1'b1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        btn_start = 1'b0;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic chk_pos(input string n, input int x, input int y, input int r);
        expect_v({n, "_x"}, 0, x);
        expect_v({n, "_y"}, 1, y);
        expect_v({n, "_run"}, 2, r);
        @(negedge CLOCK);
    endtask

    task automatic pixchk(input string n, input int idx, input int v);
        @(negedge CLOCK);
        pixel_index = 13'(idx);
        @(posedge CLOCK);
        expect_v(n, 3, v);
        @(negedge CLOCK);
    endtask

    initial begin
        RST_N = 1'b0;
        {btn_start, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        speed_sel = 1'b0; wrap_en = 1'b0; pixel_index = 13'd0;

        // reset state
        expect_v("rst_x", 0, 45); expect_v("rst_y", 1, 55);
        expect_v("rst_run", 2, 0); expect_v("rst_pix", 3, 0); expect_v("rst_cnt", 4, 0);
        @(negedge CLOCK);
        @(posedge CLOCK); #2 RST_N = 1'b1;
        repeat (2) @(negedge CLOCK);

        // idle marker box and its edges
        pixchk("idle_pix_2_2", 2*96+2, 16'h001F);
        pixchk("idle_pix_0",   0,      16'h0000);
        pixchk("idle_pix_7_7", 7*96+7, 16'h001F);
        pixchk("idle_pix_y8",  8*96+2, 16'h0000);
        pixchk("idle_pix_x8",  2*96+8, 16'h0000);

        // direction buttons ignored while idle
        press(4'b0001, 10);
        chk_pos("idle_btn", 45, 55, 0);

        start_pulse();
        chk_pos("start", 45, 55, 1);
        pixchk("run_pix_tl", 55*96+45, 16'hFFFF);
        pixchk("run_pix_br", 60*96+50, 16'hFFFF);
        pixchk("run_pix_yb", 61*96+45, 16'h0000);
        pixchk("run_pix_xr", 55*96+51, 16'h0000);
        pixchk("run_pix_ya", 54*96+45, 16'h0000);
        pixchk("run_pix_idlebox", 2*96+2, 16'h0000);

        // right held, fast: steps on posedges 3,7,11 after the press
        @(negedge CLOCK);
        btn_right = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge CLOCK);
            expect_v("right_walk_x", 0, (k >= 3) ? 45 + (k - 3) / 4 + 1 : 45);
            expect_v("right_walk_y", 1, 55);
        end
        @(negedge CLOCK);
        btn_right = 1'b0;
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
        chk_pos("right_done", 48, 55, 1);

        // opposing X buttons cancel
        @(negedge CLOCK);
        btn_left = 1'b1; btn_right = 1'b1;
        repeat (10) @(posedge CLOCK);
        expect_v("lr_cnt", 4, 0); expect_v("lr_x_mid", 0, 48);
        repeat (10) @(posedge CLOCK);
        @(negedge CLOCK);
        btn_left = 1'b0; btn_right = 1'b0;
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
        chk_pos("lr_done", 48, 55, 1);

        // slow speed: 16 cycles -> 2 steps
        speed_sel = 1'b1;
        press(4'b0001, 16);
        chk_pos("slow", 50, 55, 1);
        speed_sel = 1'b0;

        // diagonal up+right: 8 cycles -> 2 steps each
        press(4'b1001, 8);
        chk_pos("diag", 52, 53, 1);
        press(4'b0010, 4);
        chk_pos("left1", 51, 53, 1);
        press(4'b0100, 5);
        chk_pos("down2", 51, 55, 1);

        // clamp at right bound
        press(4'b0001, 200);
        chk_pos("clamp_r", 88, 55, 1);
        press(4'b0001, 8);
        chk_pos("clamp_r2", 88, 55, 1);

        // wrap at X bounds
        wrap_en = 1'b1;
        press(4'b0001, 1);
        chk_pos("wrap_r", 2, 55, 1);
        press(4'b0010, 1);
        chk_pos("wrap_l", 88, 55, 1);
        wrap_en = 1'b0;

        // clamp at top, then wrap from top
        press(4'b1000, 240);
        chk_pos("clamp_up", 88, 2, 1);
        wrap_en = 1'b1;
        press(4'b1000, 1);
        chk_pos("wrap_up", 88, 56, 1);
        wrap_en = 1'b0;

        // start while running reloads the origin
        start_pulse();
        chk_pos("restart", 45, 55, 1);

        // reset in the middle of a press
        @(negedge CLOCK);
        btn_right = 1'b1;
        repeat (6) @(posedge CLOCK);
        expect_v("pre_rst_x", 0, 46);
        @(negedge CLOCK);
        @(posedge CLOCK);
        #2 RST_N = 1'b0;
        expect_v("mid_rst_x", 0, 45); expect_v("mid_rst_y", 1, 55);
        expect_v("mid_rst_run", 2, 0); expect_v("mid_rst_pix", 3, 0);
        expect_v("mid_rst_cnt", 4, 0);
        @(negedge CLOCK);
        @(posedge CLOCK);
        #2 RST_N = 1'b1;
        repeat (10) @(posedge CLOCK);
        @(negedge CLOCK);
        chk_pos("post_rst_hold", 45, 55, 0);
        btn_right = 1'b0;
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
        start_pulse();
        chk_pos("post_rst_start", 45, 55, 1);

        @(negedge CLOCK);
        @(posedge CLOCK);
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
